bnn_host_driver: RTL and testbench

BNN_HOST_DRIVER -- requirements
Module: bnn_host_driver

---
 rtl/bnn_host_driver.sv | 174 +++++++++++++++++
 tb/tb_bnn_host_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bnn_host_driver.sv
// bnn_host_driver: streams one image's pixel and weight bytes bit-serially into
// the BNN accelerator, then waits a fixed time and captures its 4-bit answer.

module bnn_host_stream #(
    parameter int BYTES = 98
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       run_nx,
    input  logic       take,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       loaded,
    output logic       bit0
);
    localparam int RW = $clog2(BYTES + 1);

    logic [7:0]    sr, sr_nx, hb, hb_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          hb_full, hbf_nx, accept;
    logic [RW-1:0] req, req_nx;

    assign accept = valid && ready;
    assign loaded = cnt != 4'd0;
    assign bit0   = sr[0];

    // ready depends only on the holding buffer, so a byte always has a slot
    always_comb begin
        sr_nx  = take ? sr >> 1 : sr;
        cnt_nx = take ? cnt - 4'd1 : cnt;
        hb_nx  = hb;
        hbf_nx = hb_full;
        req_nx = req + RW'(accept);
        if (take && cnt == 4'd1 && hb_full) begin
            sr_nx  = hb;
            cnt_nx = 4'd8;
            hbf_nx = 1'b0;
        end else if (accept && cnt_nx == 4'd0) begin
            sr_nx  = data;
            cnt_nx = 4'd8;
        end else if (accept) begin
            hb_nx  = data;
            hbf_nx = 1'b1;
        end
        if (clr) begin
            cnt_nx = '0;
            hbf_nx = 1'b0;
            req_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            hb      <= '0;
            cnt     <= '0;
            hb_full <= 1'b0;
            req     <= '0;
            ready   <= 1'b0;
        end else begin
            sr      <= sr_nx;
            hb      <= hb_nx;
            cnt     <= cnt_nx;
            hb_full <= hbf_nx;
            req     <= req_nx;
            ready   <= run_nx && !hbf_nx && (req_nx < RW'(BYTES));
        end
    end
endmodule

module bnn_host_driver #(
    parameter int PIX_BITS    = 784,
    parameter int WGT_BITS    = 2320,
    parameter int WAIT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] pix_byte,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] wgt_byte,
    input  logic       wgt_valid,
    output logic       wgt_ready,
    output logic       bnn_mode,
    output logic       bnn_d_p,
    output logic       bnn_d_w,
    input  logic [3:0] bnn_answer,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       err_underrun
);
    localparam int BW = $clog2(WGT_BITS + 1);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] wait_cnt;
    logic          go, more, need_p, underrun, issue, take_p, run_nx, last_wait;
    logic          p_loaded, w_loaded, p_bit, w_bit;

    assign go        = start && (state == IDLE || state == DONE);
    assign more      = bit_cnt < BW'(WGT_BITS);
    assign need_p    = bit_cnt < BW'(PIX_BITS);
    assign underrun  = state == SHIFT && more && (!w_loaded || (need_p && !p_loaded));
    assign issue     = (state == PREFETCH && p_loaded && w_loaded) || (state == SHIFT && more && !underrun);
    assign take_p    = issue && need_p;
    assign last_wait = state == WAIT && wait_cnt == CW'(WAIT_CYCLES - 1);
    assign run_nx    = state_nx == PREFETCH || state_nx == SHIFT;

    bnn_host_stream #(.BYTES(PIX_BITS / 8)) u_pix (
        .clk(clk), .rst_n(rst_n), .clr(go), .run_nx(run_nx), .take(take_p),
        .data(pix_byte), .valid(pix_valid), .ready(pix_ready),
        .loaded(p_loaded), .bit0(p_bit)
    );

    bnn_host_stream #(.BYTES(WGT_BITS / 8)) u_wgt (
        .clk(clk), .rst_n(rst_n), .clr(go), .run_nx(run_nx), .take(issue),
        .data(wgt_byte), .valid(wgt_valid), .ready(wgt_ready),
        .loaded(w_loaded), .bit0(w_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = PREFETCH;
            PREFETCH:   if (p_loaded && w_loaded) state_nx = SHIFT;
            SHIFT:      state_nx = underrun ? IDLE : (more ? SHIFT : WAIT);
            WAIT:       if (last_wait) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // the bit issued on an edge is the one presented during the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bnn_d_w      <= 1'b0;
            bnn_d_p      <= 1'b0;
            bnn_mode     <= 1'b0;
            busy         <= 1'b0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            bnn_d_w  <= issue && w_bit;
            bnn_d_p  <= take_p && p_bit;
            bnn_mode <= state_nx == SHIFT || state_nx == WAIT;
            busy     <= state_nx == PREFETCH || state_nx == SHIFT || state_nx == WAIT;
            bit_cnt  <= go ? '0 : bit_cnt + BW'(issue);
            wait_cnt <= state == WAIT ? wait_cnt + CW'(1) : '0;
            if (go) begin
                result_valid <= 1'b0;
                err_underrun <= 1'b0;
            end
            if (underrun) err_underrun <= 1'b1;
            if (last_wait) begin
                result       <= bnn_answer;
                result_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bnn_host_driver.sv
// tb_bnn_host_driver: directed runs of bnn_host_driver with a byte-source model
// and a bit-stream monitor that rebuilds the expected serial sequence.

module tb_bnn_host_driver;
    localparam int PIX  = 784;
    localparam int WGT  = 2320;
    localparam int WAIT = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pix_byte = '0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] wgt_byte = '0;
    logic       wgt_valid = 1'b0;
    logic       wgt_ready;
    logic       bnn_mode, bnn_d_p, bnn_d_w;
    logic [3:0] bnn_answer = 4'h7;
    logic [3:0] result;
    logic       result_valid, busy, err_underrun;

    int  checks = 0;
    int  errors = 0;
    bit  throttle = 1'b0;
    int  w_limit = 1 << 30;
    int  k, w_bad, p_bad, tail_bad;

    bnn_host_driver #(.PIX_BITS(PIX), .WGT_BITS(WGT), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pix_byte(pix_byte), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .wgt_byte(wgt_byte), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .bnn_mode(bnn_mode), .bnn_d_p(bnn_d_p), .bnn_d_w(bnn_d_w),
        .bnn_answer(bnn_answer), .result(result), .result_valid(result_valid),
        .busy(busy), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_w(input int i);
        logic [7:0] b;
        b = ~8'(i / 8);
        return i < WGT ? b[i % 8] : 1'b0;
    endfunction

    function automatic logic exp_p(input int i);
        logic [7:0] b;
        b = 8'(i / 8);
        return i < PIX ? b[i % 8] : 1'b0;
    endfunction

    // byte sources: pixel byte n = n, weight byte n = ~n
    initial begin
        int  p_n = 0, w_n = 0, cyc = 0;
        bit  p_go, w_go, slot;
        forever begin
            @(negedge clk);
            if (!busy) begin
                p_n = 0;
                w_n = 0;
            end
            p_go = pix_valid && pix_ready;
            w_go = wgt_valid && wgt_ready;
            @(posedge clk);
            if (p_go) p_n++;
            if (w_go) w_n++;
            #1;
            cyc++;
            slot      = !throttle || (cyc % 4 == 0);
            pix_valid = slot;
            pix_byte  = 8'(p_n);
            wgt_valid = slot && (w_n < w_limit);
            wgt_byte  = ~8'(w_n);
        end
    end

    // k is the SHIFT cycle index; counters restart while PREFETCH is seen
    initial begin
        k = 0; w_bad = 0; p_bad = 0; tail_bad = 0;
        forever begin
            @(negedge clk);
            if (busy && !bnn_mode) begin
                k = 0; w_bad = 0; p_bad = 0; tail_bad = 0;
            end else if (bnn_mode) begin
                if (bnn_d_w !== exp_w(k)) w_bad++;
                if (bnn_d_p !== exp_p(k)) begin
                    if (k >= PIX && k < WGT) tail_bad++;
                    else p_bad++;
                end
                k++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_mode();
        int n = 0;
        while (!bnn_mode && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mode_rise", bnn_mode, 1);
    endtask

    task automatic finish_run(input logic [3:0] ans);
        int n = 0;
        while (!result_valid && n < 7000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", result_valid, 1);
        check("result", result, ans);
        check("busy_done", busy, 0);
        check("mode_done", bnn_mode, 0);
        check("mode_len", k, WGT + WAIT);
        check("w_stream", w_bad, 0);
        check("p_stream", p_bad, 0);
        check("p_tail", tail_bad, 0);
        check("no_underrun", err_underrun, 0);
    endtask

    initial begin
        #12;
        check("reset_outs", {result, result_valid, busy, err_underrun, bnn_mode, bnn_d_p, bnn_d_w, pix_ready, wgt_ready}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", {busy, pix_ready, wgt_ready}, 0);

        // nominal run, with a start pulse in SHIFT that must be ignored
        bnn_answer = 4'h7;
        pulse_start();
        check("prefetch", {busy, bnn_mode, pix_ready, wgt_ready}, 4'b1011);
        wait_mode();
        repeat (100) @(negedge clk);
        pulse_start();
        check("ignored_start", {busy, bnn_mode, err_underrun}, 3'b110);
        finish_run(4'h7);

        // start from DONE with a throttled source
        throttle   = 1'b1;
        bnn_answer = 4'hA;
        pulse_start();
        check("done_restart", {busy, result_valid}, 2'b10);
        check("result_held", result, 4'h7);
        wait_mode();
        finish_run(4'hA);

        // weight source stops after 10 bytes
        throttle = 1'b0;
        w_limit  = 10;
        pulse_start();
        wait_mode();
        repeat (79) @(negedge clk);
        check("pre_underrun", {err_underrun, bnn_mode}, 2'b01);
        @(negedge clk);
        check("underrun_err", {err_underrun, busy}, 2'b10);
        @(negedge clk);
        check("underrun_idle", {bnn_mode, result_valid, wgt_ready, bnn_d_w, bnn_d_p}, 0);

        // asynchronous reset at SHIFT cycle 500, then a fresh nominal run
        w_limit    = 1 << 30;
        bnn_answer = 4'h7;
        pulse_start();
        check("underrun_clear", err_underrun, 0);
        wait_mode();
        repeat (500) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", {result, result_valid, busy, err_underrun, bnn_mode, bnn_d_p, bnn_d_w, pix_ready, wgt_ready}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", {busy, bnn_mode, result_valid, pix_ready}, 0);
        pulse_start();
        wait_mode();
        finish_run(4'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
